// File: rtl/byte_mem_sequencer.sv
// byte_mem_sequencer: turns one byte/half/word load or store into little-endian
// byte accesses on an 8-bit synchronous RAM port, extending load data to 32 bits.
`default_nettype none

module byte_mem_sequencer #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic [7:0]        mem_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;

    logic [1:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt;
    logic [31:0] asm_q;
    logic [1:0]  last_idx;
    logic [31:0] full_word;
    logic [31:0] ext_word;

    assign req_ready = (state == IDLE);

    always_comb begin
        case (size_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Final byte arrives on mem_dout during CAPT; merge it before extending.
    always_comb begin
        full_word = asm_q;
        full_word[{cnt, 3'b000} +: 8] = mem_dout;
    end

    always_comb begin
        case (size_q)
            2'b00:   ext_word = {{24{~uns_q & full_word[7]}}, full_word[7:0]};
            2'b01:   ext_word = {{16{~uns_q & full_word[15]}}, full_word[15:0]};
            default: ext_word = full_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            wdata_q   <= 32'd0;
            cnt       <= 2'd0;
            asm_q     <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_addr  <= '0;
            mem_din   <= 8'd0;
            mem_we    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        wdata_q  <= req_wdata;
                        cnt      <= 2'd0;
                        mem_addr <= req_addr;
                        mem_we   <= req_we;
                        if (req_we) begin
                            mem_din <= req_wdata[7:0];
                        end
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Read data lags the address by one cycle: byte cnt-1 is on mem_dout now.
                    if (cnt != 2'd0) begin
                        asm_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_dout;
                    end
                    if (cnt == last_idx) begin
                        mem_we <= 1'b0;
                        if (we_q) begin
                            rsp_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= CAPT;
                        end
                    end else begin
                        cnt      <= cnt + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        if (we_q) begin
                            mem_din <= wdata_q[{cnt + 2'd1, 3'b000} +: 8];
                        end
                    end
                end
                CAPT: begin
                    rsp_rdata <= ext_word;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_byte_mem_sequencer.sv
// tb_byte_mem_sequencer: directed load/store sequences against a behavioural
// 32K x 8 synchronous RAM, with a response scoreboard checking data and latency.
`default_nettype none

module tb_byte_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [14:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout;

    logic [7:0]  ram [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    byte_mem_sequencer #(.ADDR_W(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $error("FAIL unexpected_rsp: observed rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                if (e.is_load) chk("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    task automatic poke(input logic [14:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Leaves req_valid high on return (one cycle after accept); caller drops it.
    task automatic send(input logic we, input logic [14:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic [31:0] exp,
                        output int t);
        int n;
        int guard;
        exp_t e;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        req_we = we; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            fails++;
            $error("FAIL accept_timeout: observed req_ready=0 expected 1");
        end
        t = cyc;
        e.is_load = ~we;
        e.data    = exp;
        e.due     = cyc + n + (we ? 1 : 2);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int t1;
        int t2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        poke(15'h0040, 8'h80);
        poke(15'h7FFF, 8'h34);
        poke(15'h0000, 8'h12);
        poke(15'h0200, 8'hA5);
        poke(15'h0203, 8'h5A);
        poke(15'h0010, 8'h00);
        poke(15'h0011, 8'h00);
        poke(15'h0012, 8'h00);
        poke(15'h0013, 8'h00);

        // Word store then word load at 0x0100
        send(1'b1, 15'h0100, 2'b10, 1'b0, 32'h11223344, 32'h0, t1);
        req_valid = 1'b0;
        drain();
        chk("st_w_ram100", 32'(ram[15'h0100]), 32'h44);
        chk("st_w_ram101", 32'(ram[15'h0101]), 32'h33);
        chk("st_w_ram102", 32'(ram[15'h0102]), 32'h22);
        chk("st_w_ram103", 32'(ram[15'h0103]), 32'h11);
        send(1'b0, 15'h0100, 2'b10, 1'b0, 32'h0, 32'h11223344, t1);
        req_valid = 1'b0;
        drain();

        // Byte load, signed and unsigned
        send(1'b0, 15'h0040, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, t1);
        req_valid = 1'b0;
        drain();
        send(1'b0, 15'h0040, 2'b00, 1'b1, 32'h0, 32'h00000080, t1);
        req_valid = 1'b0;
        drain();

        // Unaligned half store
        send(1'b1, 15'h0201, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, t1);
        req_valid = 1'b0;
        drain();
        chk("st_h_ram200", 32'(ram[15'h0200]), 32'hA5);
        chk("st_h_ram201", 32'(ram[15'h0201]), 32'hEF);
        chk("st_h_ram202", 32'(ram[15'h0202]), 32'hBE);
        chk("st_h_ram203", 32'(ram[15'h0203]), 32'h5A);
        send(1'b0, 15'h0201, 2'b01, 1'b0, 32'h0, 32'hFFFFBEEF, t1);
        req_valid = 1'b0;
        drain();

        // Half load across the address wrap
        send(1'b0, 15'h7FFF, 2'b01, 1'b1, 32'h0, 32'h00001234, t1);
        req_valid = 1'b0;
        chk("wrap_addr0", 32'(mem_addr), 32'h7FFF);
        @(posedge clk); #1;
        chk("wrap_addr1", 32'(mem_addr), 32'h0000);
        drain();

        // Size 11 behaves as word
        send(1'b0, 15'h0100, 2'b11, 1'b1, 32'h0, 32'h11223344, t1);
        req_valid = 1'b0;
        drain();

        // Back-to-back: load accepted in the store's response cycle
        send(1'b1, 15'h0300, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, t1);
        send(1'b0, 15'h0300, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, t2);
        req_valid = 1'b0;
        chk("b2b_accept_cycle", 32'(t2), 32'(t1 + 5));
        chk("b2b_first_load_addr", 32'(mem_addr), 32'h0300);
        drain();

        // Reset in the middle of a word store at 0x0010
        send(1'b1, 15'h0010, 2'b10, 1'b0, 32'hDDCCBBAA, 32'h0, t1);
        req_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_we_t3", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("abort_we_t4", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_ram10", 32'(ram[15'h0010]), 32'hAA);
        chk("abort_ram11", 32'(ram[15'h0011]), 32'hBB);
        chk("abort_ram12", 32'(ram[15'h0012]), 32'h00);
        chk("abort_ram13", 32'(ram[15'h0013]), 32'h00);

        // Sequencer still works after the abort
        send(1'b0, 15'h0010, 2'b01, 1'b1, 32'h0, 32'h0000BBAA, t1);
        req_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
